// File: rtl/o_serdes_shifter.sv
// o_serdes_shifter: double-buffered LSB-first SDR/DDR output serializer with lock-qualified clock enable
module o_serdes_shifter #(
  parameter string DATA_RATE  = "SDR",
  parameter int    WIDTH      = 4,
  parameter int    LOCK_WAIT  = 256,
  parameter logic  IDLE_VALUE = 1'b0
) (
  input  logic             PLL_CLK,
  input  logic             RST,
  input  logic             PLL_LOCK,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  input  logic             OE_IN,
  output logic             LOAD_READY,
  output logic [1:0]       Q,
  output logic             OE_OUT,
  output logic             CLK_EN_OUT,
  output logic             UNDERRUN
);
  localparam int B = (DATA_RATE == "DDR") ? 2 : 1;
  localparam int N = WIDTH / B;
  typedef enum logic {WAIT, RUN} state_t;
  state_t state, state_nx;
  logic lock_m, lock_s, hold_full, hold_oe, active, last, load;
  logic [8:0] wait_cnt;
  logic [3:0] beat;
  logic [WIDTH-1:0] hold_d, shreg, src;
  logic [1:0] beat_q;
  // The holding register feeds the shifter whenever it is idle or finishing its final beat.
  assign last       = active && beat == 4'(N - 1);
  assign load       = hold_full && (!active || last);
  assign src        = load ? hold_d : shreg;
  assign beat_q     = (B == 2) ? src[1:0] : {2{src[0]}};
  assign LOAD_READY = (state == RUN) && (!hold_full || last);
  always_comb begin
    state_nx = state;
    if (state == WAIT && lock_s && wait_cnt == 9'(LOCK_WAIT - 1)) state_nx = RUN;
    if (state == RUN && !lock_s) state_nx = WAIT;
  end
  always_ff @(posedge PLL_CLK or posedge RST)
    if (RST) state <= WAIT;
    else state <= state_nx;
  always_ff @(posedge PLL_CLK or posedge RST) begin
    if (RST) begin
      lock_m     <= 1'b0;
      lock_s     <= 1'b0;
      wait_cnt   <= 9'd0;
      hold_full  <= 1'b0;
      hold_oe    <= 1'b0;
      hold_d     <= '0;
      shreg      <= '0;
      active     <= 1'b0;
      beat       <= 4'd0;
      Q          <= {2{IDLE_VALUE}};
      OE_OUT     <= 1'b0;
      CLK_EN_OUT <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      lock_m     <= PLL_LOCK;
      lock_s     <= lock_m;
      UNDERRUN   <= 1'b0;
      CLK_EN_OUT <= state_nx == RUN;
      wait_cnt   <= (state == WAIT && lock_s) ? wait_cnt + 9'd1 : 9'd0;
      if (state_nx != RUN) begin
        hold_full <= 1'b0;
        active    <= 1'b0;
        Q         <= {2{IDLE_VALUE}};
        OE_OUT    <= 1'b0;
      end else begin
        if (LOAD_READY && DATA_VALID) begin
          hold_d    <= D;
          hold_oe   <= OE_IN;
          hold_full <= 1'b1;
        end else if (load) hold_full <= 1'b0;
        if (load || (active && !last)) begin
          Q      <= beat_q;
          shreg  <= src >> B;
          beat   <= load ? 4'd0 : beat + 4'd1;
          active <= 1'b1;
          if (load) OE_OUT <= hold_oe;
        end else if (last) begin
          active   <= 1'b0;
          Q        <= {2{IDLE_VALUE}};
          OE_OUT   <= 1'b0;
          UNDERRUN <= 1'b1;
        end
      end
    end
  end
endmodule
